latency_mc: RTL and testbench

//  Multi-channel, parametrised successor to the single-channel issue/retire latency counter.
//  - Tracks in-flight operations per channel.
//  - Accumulates issue counts and aggregate latency (sum over cycles of outstanding ops) per channel and in total.
//  - Mean latency = aggregate / issue, computed by software.
//  - Sits beside a request/response engine as a perf monitor; adds freeze, per-channel readback and error flags.

---
 rtl/latency_pkg.sv | 36 +++
 rtl/latency_chan.sv | 99 +++++++++
 rtl/latency_mc.sv | 138 +++++++++++++
 tb/tb_latency_mc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/latency_pkg.sv
// Shared types and helpers for the multi-channel latency monitor.
// Optional feature macro used by the design files: LATENCY_PEAK_EN.
package latency_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_e;

    function automatic int chw(input int n);
        if (n > 1) return $clog2(n);
        else       return 1;
    endfunction

    function automatic int ow(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    // All-ones value of a w-bit counter, carried in 64 bits (w <= 63).
    function automatic logic [63:0] sat_lim(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, sat_lim(w)}) return sat_lim(w);
        else                        return s[63:0];
    endfunction

    // True when a non-zero increment drives the counter onto its ceiling.
    function automatic logic sat_hit(input logic [63:0] a, input logic [63:0] b, input int w);
        return (b != 64'd0) && (({1'b0, a} + {1'b0, b}) >= {1'b0, sat_lim(w)});
    endfunction

endpackage

// File: rtl/latency_chan.sv
// One channel of the latency monitor: outstanding count, issue count, aggregate latency.
// LATENCY_PEAK_EN adds a per-channel peak outstanding register.
module latency_chan
    import latency_pkg::*;
#(
    parameter int W       = 32,
    parameter int MAX_OUT = 15,
    parameter int OW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic          retire,
    input  logic          clear,
    input  logic          run,
    output logic [OW-1:0] outstanding_r,
    output logic [W-1:0]  issue_cnt_r,
    output logic [W-1:0]  aggregate_r,
`ifdef LATENCY_PEAK_EN
    output logic [OW-1:0] peak_r,
`endif
    output logic          accept_s,
    output logic          underflow_s,
    output logic          overflow_s,
    output logic          sat_s
);

    logic [OW-1:0] out_next_s;
    logic          count_s;

    assign count_s = run && !clear;

    // Outstanding next value and the accept/error pulses for this edge.
    always_comb begin
        accept_s    = 1'b0;
        underflow_s = 1'b0;
        overflow_s  = 1'b0;
        out_next_s  = outstanding_r;
        if (issue && !retire) begin
            if (outstanding_r == OW'(MAX_OUT)) begin
                overflow_s = 1'b1;
            end else begin
                accept_s   = 1'b1;
                out_next_s = outstanding_r + OW'(1'b1);
            end
        end else if (retire && !issue) begin
            if (outstanding_r == '0) begin
                underflow_s = 1'b1;
            end else begin
                out_next_s = outstanding_r - OW'(1'b1);
            end
        end else if (issue && retire) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Saturation event only counts when the increment would actually be applied.
    always_comb begin
        sat_s = 1'b0;
        if (count_s) begin
            sat_s = (accept_s && sat_hit(64'(issue_cnt_r), 64'd1, W)) ||
                    sat_hit(64'(aggregate_r), 64'(outstanding_r), W);
        end else begin
            sat_s = 1'b0;
        end
    end

    // Channel state; aggregate adds the pre-update outstanding value.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= '0;
            issue_cnt_r   <= '0;
            aggregate_r   <= '0;
        end else begin
            outstanding_r <= out_next_s;
            if (clear) begin
                issue_cnt_r <= '0;
                aggregate_r <= '0;
            end else if (run) begin
                if (accept_s) issue_cnt_r <= W'(sat_add(64'(issue_cnt_r), 64'd1, W));
                aggregate_r <= W'(sat_add(64'(aggregate_r), 64'(outstanding_r), W));
            end
        end
    end

`ifdef LATENCY_PEAK_EN
    // Peak tracks the post-update outstanding value while running.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            peak_r <= '0;
        end else if (run && (out_next_s > peak_r)) begin
            peak_r <= out_next_s;
        end
    end
`endif

endmodule

// File: rtl/latency_mc.sv
// Multi-channel issue/retire latency monitor: FSM, totals, readback mux, sticky flags.
// Define LATENCY_PEAK_EN to add the per-channel peak_out_r output.
module latency_mc
    import latency_pkg::*;
#(
    parameter  int W       = 32,
    parameter  int NCH     = 4,
    parameter  int MAX_OUT = 15,
    localparam int OW      = ow(MAX_OUT),
    localparam int CHW     = chw(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    issue,
    input  logic [NCH-1:0]    retire,
    input  logic              clear,
    input  logic              freeze,
    input  logic [CHW-1:0]    rd_ch,
    output logic [W-1:0]      issue_cnt_r,
    output logic [W-1:0]      aggregate_cnt_r,
    output logic [NCH*OW-1:0] outstanding_r,
    output logic [W-1:0]      rd_issue_cnt_r,
    output logic [W-1:0]      rd_aggregate_r,
    output logic              frozen_r,
`ifdef LATENCY_PEAK_EN
    output logic [NCH*OW-1:0] peak_out_r,
`endif
    output logic              err_underflow_r,
    output logic              err_overflow_r,
    output logic              sat_r
);

    localparam int PCW  = $clog2(NCH + 1);
    localparam int SUMW = OW + $clog2(NCH + 1);

    state_e            state_r, next_s;
    logic              run_s;
    logic [W-1:0]      chan_issue_s [NCH];
    logic [W-1:0]      chan_agg_s   [NCH];
    logic [NCH-1:0]    acc_s, uf_s, of_s, csat_s;
    logic [PCW-1:0]    pop_s;
    logic [SUMW-1:0]   sum_s;
    logic              tot_sat_s;

    assign run_s = (state_r == RUN);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        latency_chan #(.W(W), .MAX_OUT(MAX_OUT), .OW(OW)) u_chan (
            .clk           (clk),
            .rst           (rst),
            .issue         (issue[c]),
            .retire        (retire[c]),
            .clear         (clear),
            .run           (run_s),
            .outstanding_r (outstanding_r[c*OW +: OW]),
            .issue_cnt_r   (chan_issue_s[c]),
            .aggregate_r   (chan_agg_s[c]),
`ifdef LATENCY_PEAK_EN
            .peak_r        (peak_out_r[c*OW +: OW]),
`endif
            .accept_s      (acc_s[c]),
            .underflow_s   (uf_s[c]),
            .overflow_s    (of_s[c]),
            .sat_s         (csat_s[c])
        );
    end

    // Run/freeze next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            RUN:     if (freeze) next_s = FROZEN; else next_s = RUN;
            FROZEN:  if (freeze) next_s = FROZEN; else next_s = RUN;
            default: next_s = RUN;
        endcase
    end

    // State register with frozen_r registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RUN;
            frozen_r <= 1'b0;
        end else begin
            state_r  <= next_s;
            frozen_r <= (next_s == FROZEN);
        end
    end

    // Cross-channel accepted-issue popcount and outstanding sum, widened to never overflow.
    always_comb begin
        pop_s = '0;
        sum_s = '0;
        for (int c = 0; c < NCH; c++) begin
            pop_s = pop_s + PCW'(acc_s[c]);
            sum_s = sum_s + SUMW'(outstanding_r[c*OW +: OW]);
        end
        if (run_s && !clear) begin
            tot_sat_s = sat_hit(64'(issue_cnt_r), 64'(pop_s), W) ||
                        sat_hit(64'(aggregate_cnt_r), 64'(sum_s), W);
        end else begin
            tot_sat_s = 1'b0;
        end
    end

    // Totals and sticky flags; clear wins over any event in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            issue_cnt_r     <= '0;
            aggregate_cnt_r <= '0;
            err_underflow_r <= 1'b0;
            err_overflow_r  <= 1'b0;
            sat_r           <= 1'b0;
        end else begin
            if (run_s) begin
                issue_cnt_r     <= W'(sat_add(64'(issue_cnt_r), 64'(pop_s), W));
                aggregate_cnt_r <= W'(sat_add(64'(aggregate_cnt_r), 64'(sum_s), W));
            end
            if (|uf_s) err_underflow_r <= 1'b1;
            if (|of_s) err_overflow_r  <= 1'b1;
            if ((|csat_s) || tot_sat_s) sat_r <= 1'b1;
        end
    end

    // Readback of the selected channel; out-of-range selects read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_issue_cnt_r <= '0;
            rd_aggregate_r <= '0;
        end else if (int'(rd_ch) < NCH) begin
            rd_issue_cnt_r <= chan_issue_s[rd_ch];
            rd_aggregate_r <= chan_agg_s[rd_ch];
        end else begin
            rd_issue_cnt_r <= '0;
            rd_aggregate_r <= '0;
        end
    end

endmodule

// File: tb/tb_latency_mc.sv
// Self-checking bench for latency_mc: a vector table plus hand-written multi-cycle sequences.
// A second, narrow instance (W=8, NCH=3) covers saturation and out-of-range readback.
module tb_latency_mc;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  issue, retire;
    logic        clear, freeze;
    logic [1:0]  rd_ch;
    logic [31:0] issue_cnt_r, aggregate_cnt_r, rd_issue_cnt_r, rd_aggregate_r;
    logic [15:0] outstanding_r;
    logic        frozen_r, err_underflow_r, err_overflow_r, sat_r;

    logic [2:0]  issue2, retire2;
    logic        clear2, freeze2;
    logic [1:0]  rd_ch2;
    logic [7:0]  issue_cnt2, agg2, rd_issue2, rd_agg2;
    logic [11:0] out2;
    logic        frozen2, uf2, of2, sat2;
`ifdef LATENCY_PEAK_EN
    logic [15:0] peak_out_r;
    logic [11:0] peak2;
`endif

    latency_mc #(.W(32), .NCH(4), .MAX_OUT(15)) dut (
        .clk(clk), .rst(rst), .issue(issue), .retire(retire), .clear(clear), .freeze(freeze),
        .rd_ch(rd_ch), .issue_cnt_r(issue_cnt_r), .aggregate_cnt_r(aggregate_cnt_r),
        .outstanding_r(outstanding_r), .rd_issue_cnt_r(rd_issue_cnt_r), .rd_aggregate_r(rd_aggregate_r),
        .frozen_r(frozen_r),
`ifdef LATENCY_PEAK_EN
        .peak_out_r(peak_out_r),
`endif
        .err_underflow_r(err_underflow_r), .err_overflow_r(err_overflow_r), .sat_r(sat_r)
    );

    latency_mc #(.W(8), .NCH(3), .MAX_OUT(15)) dut_s (
        .clk(clk), .rst(rst), .issue(issue2), .retire(retire2), .clear(clear2), .freeze(freeze2),
        .rd_ch(rd_ch2), .issue_cnt_r(issue_cnt2), .aggregate_cnt_r(agg2),
        .outstanding_r(out2), .rd_issue_cnt_r(rd_issue2), .rd_aggregate_r(rd_agg2),
        .frozen_r(frozen2),
`ifdef LATENCY_PEAK_EN
        .peak_out_r(peak2),
`endif
        .err_underflow_r(uf2), .err_overflow_r(of2), .sat_r(sat2)
    );

    typedef struct {
        logic [3:0]  iss;
        logic [3:0]  ret;
        logic        clr;
        logic [31:0] e_iss;
        logic [31:0] e_agg;
        logic [15:0] e_out;
        logic        e_uf;
    } vec_t;

    vec_t vecs [10];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string nm, input logic [31:0] e_iss, input logic [31:0] e_agg,
                            input logic [15:0] e_out);
        chk({nm, " issue_cnt"}, issue_cnt_r, e_iss);
        chk({nm, " aggregate"}, aggregate_cnt_r, e_agg);
        chk({nm, " outstanding"}, outstanding_r, e_out);
    endtask

    initial begin
        vecs[0] = '{4'h0, 4'h0, 1'b0, 32'd0, 32'd0,  16'h0000, 1'b0};
        vecs[1] = '{4'h1, 4'h0, 1'b0, 32'd1, 32'd0,  16'h0001, 1'b0};
        vecs[2] = '{4'h2, 4'h0, 1'b0, 32'd2, 32'd1,  16'h0011, 1'b0};
        vecs[3] = '{4'h3, 4'h1, 1'b0, 32'd4, 32'd3,  16'h0021, 1'b0};
        vecs[4] = '{4'h0, 4'h2, 1'b0, 32'd4, 32'd6,  16'h0011, 1'b0};
        vecs[5] = '{4'h0, 4'h4, 1'b0, 32'd4, 32'd8,  16'h0011, 1'b1};
        vecs[6] = '{4'h0, 4'h3, 1'b0, 32'd4, 32'd10, 16'h0000, 1'b1};
        vecs[7] = '{4'h0, 4'h0, 1'b1, 32'd0, 32'd0,  16'h0000, 1'b0};
        vecs[8] = '{4'h1, 4'h0, 1'b0, 32'd1, 32'd0,  16'h0001, 1'b0};
        vecs[9] = '{4'h0, 4'h1, 1'b0, 32'd1, 32'd1,  16'h0000, 1'b0};

        rst = 1'b1; issue = 4'h0; retire = 4'h0; clear = 1'b0; freeze = 1'b0; rd_ch = 2'd0;
        issue2 = 3'd0; retire2 = 3'd0; clear2 = 1'b0; freeze2 = 1'b0; rd_ch2 = 2'd0;
        step(); step();
        chk_main("reset", 32'd0, 32'd0, 16'h0000);
        chk("reset frozen", frozen_r, 1'b0);
        chk("reset flags", {err_underflow_r, err_overflow_r, sat_r}, 3'b000);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            issue = vecs[i].iss; retire = vecs[i].ret; clear = vecs[i].clr;
            step();
            chk_main($sformatf("vec%0d", i), vecs[i].e_iss, vecs[i].e_agg, vecs[i].e_out);
            chk($sformatf("vec%0d underflow", i), err_underflow_r, vecs[i].e_uf);
        end
        issue = 4'h0; retire = 4'h0; clear = 1'b0;

        // Reset in the middle of traffic while frozen.
        issue = 4'hF; freeze = 1'b1;
        step(); step(); step();
        chk("pre-rst frozen", frozen_r, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_main($sformatf("rst%0d", i), 32'd0, 32'd0, 16'h0000);
            chk($sformatf("rst%0d frozen", i), frozen_r, 1'b0);
            chk($sformatf("rst%0d rd", i), {rd_issue_cnt_r, rd_aggregate_r}, 64'd0);
        end
        rst = 1'b0; issue = 4'h0; freeze = 1'b0;
        step();
        chk_main("post-rst", 32'd0, 32'd0, 16'h0000);

        // Single op held 12 cycles on ch0.
        issue = 4'h1; step(); issue = 4'h0;
        repeat (11) step();
        retire = 4'h1; step(); retire = 4'h0;
        chk_main("single", 32'd1, 32'd12, 16'h0000);
        clear = 1'b1; step(); clear = 1'b0;

        // Concurrency: ch0/ch1 issue twice back-to-back, each retired 10 later.
        issue = 4'h3; step(); step(); issue = 4'h0;
        repeat (8) step();
        retire = 4'h3; step(); step(); retire = 4'h0;
        chk_main("concur", 32'd4, 32'd40, 16'h0000);
        rd_ch = 2'd2; step();
        chk("rd ch2 issue", rd_issue_cnt_r, 32'd0);
        rd_ch = 2'd1; #1;
        chk("rd latency hold", rd_issue_cnt_r, 32'd0);
        step();
        chk("rd ch1 issue", rd_issue_cnt_r, 32'd2);
        chk("rd ch1 agg", rd_aggregate_r, 32'd20);
        rd_ch = 2'd0; step();
        chk("rd ch0 agg", rd_aggregate_r, 32'd20);

        // Overflow: 16 issues into ch3.
        clear = 1'b1; step(); clear = 1'b0;
        issue = 4'h8;
        repeat (16) step();
        issue = 4'h0;
        chk_main("ovf", 32'd15, 32'd120, 16'hF000);
        chk("ovf flag", err_overflow_r, 1'b1);
        rd_ch = 2'd3; step();
        chk("ovf rd issue", rd_issue_cnt_r, 32'd15);
        chk("ovf rd agg", rd_aggregate_r, 32'd120);
`ifdef LATENCY_PEAK_EN
        chk("ovf peak", peak_out_r, 16'hF000);
`endif
        retire = 4'h8;
        repeat (15) step();
        retire = 4'h0;
        chk_main("drain", 32'd15, 32'd255, 16'h0000);
        chk("drain ovf sticky", err_overflow_r, 1'b1);

        // Freeze 8 cycles with one op in flight.
        clear = 1'b1; step(); clear = 1'b0;
        chk("clear ovf", err_overflow_r, 1'b0);
        issue = 4'h1; step(); issue = 4'h0;
        freeze = 1'b1;
        repeat (8) step();
        chk("frz frozen", frozen_r, 1'b1);
        chk_main("frz hold", 32'd1, 32'd1, 16'h0001);
        freeze = 1'b0; step();
        chk("unfrz frozen", frozen_r, 1'b0);
        repeat (10) step();
        retire = 4'h1; step(); retire = 4'h0;
        chk_main("frz total", 32'd1, 32'd12, 16'h0000);

        // Clear while frozen keeps state and outstanding.
        issue = 4'h2; step(); issue = 4'h0;
        freeze = 1'b1; step(); step();
        clear = 1'b1; step(); clear = 1'b0;
        chk_main("clr frz", 32'd0, 32'd0, 16'h0010);
        chk("clr frz frozen", frozen_r, 1'b1);
        freeze = 1'b0; step();
        chk("clr frz agg", aggregate_cnt_r, 32'd0);
        retire = 4'h2; step(); retire = 4'h0;
        chk_main("clr retire", 32'd0, 32'd1, 16'h0000);
        chk("main sat", sat_r, 1'b0);

        // Saturation on the 8-bit instance.
        issue2 = 3'd1; step(); issue2 = 3'd0;
        repeat (300) step();
        chk("sat agg", agg2, 8'd255);
        chk("sat flag", sat2, 1'b1);
        chk("sat issue", issue_cnt2, 8'd1);
        chk("sat out", out2, 12'h001);
        chk("sat rd agg", rd_agg2, 8'd255);
`ifdef LATENCY_PEAK_EN
        chk("sat peak", peak2, 12'h001);
`endif
        rd_ch2 = 2'd3; step();
        chk("rd oor issue", rd_issue2, 8'd0);
        chk("rd oor agg", rd_agg2, 8'd0);
        retire2 = 3'd1; step(); retire2 = 3'd0;
        chk("sat drained", out2, 12'h000);
        chk("sat no underflow", uf2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
